// File: rtl/trigger_wrapper.sv
`timescale 1ns/1ps
`default_nettype none
// trigger_wrapper: captures 12 trigger channels once per bunch crossing and
// reports time/amplitude channel counts, sums and a TCM trigger request.
module trigger_wrapper #(
   parameter int NCH = 12,
   parameter int TW  = 10,
   parameter int AW  = 13
) (
   input  logic                clk320,
   input  logic                rst_n,
   input  logic [2:0]          mt_cou,
   input  logic [NCH-1:0]      CH_trigt,
   input  logic [NCH-1:0]      CH_triga,
   input  logic [NCH-1:0]      CH_trigb,
   input  logic [NCH*TW-1:0]   CH_TIME_T,
   input  logic [NCH*AW-1:0]   CH_ampl0,
   output logic                tcm_req,
   output logic [17:0]         tt,
   output logic [20:0]         ta
);

   localparam int HALF = NCH / 2;
   localparam int CW   = 4;
   localparam int TSW  = 14;
   localparam int ASW  = 17;

   logic [NCH-1:0]    cap_trigt;
   logic [NCH-1:0]    cap_triga;
   logic [NCH-1:0]    cap_trigb;
   logic [NCH*TW-1:0] cap_time;
   logic [NCH*AW-1:0] cap_ampl;

   always_ff @(posedge clk320 or negedge rst_n) begin
      if (!rst_n) begin
         cap_trigt <= '0;
         cap_triga <= '0;
         cap_trigb <= '0;
         cap_time  <= '0;
         cap_ampl  <= '0;
      end else if (mt_cou == 3'd7) begin
         cap_trigt <= CH_trigt;
         cap_triga <= CH_triga;
         cap_trigb <= CH_trigb;
         cap_time  <= CH_TIME_T;
         cap_ampl  <= CH_ampl0;
      end
   end

   // First tree level: two half-sums of six channels each.
   logic [1:0][CW-1:0]  half_ncht_c, half_ncha_c, half_ncht_q, half_ncha_q;
   logic [1:0][TSW-1:0] half_tsum_c, half_tsum_q;
   logic [1:0][ASW-1:0] half_asum_c, half_asum_q;

   always_comb begin
      half_ncht_c = '0;
      half_ncha_c = '0;
      half_tsum_c = '0;
      half_asum_c = '0;
      for (int h = 0; h < 2; h++) begin
         for (int j = 0; j < HALF; j++) begin
            if (cap_trigt[h*HALF+j] && cap_trigb[h*HALF+j]) begin
               half_ncht_c[h] = half_ncht_c[h] + 4'd1;
               half_tsum_c[h] = half_tsum_c[h]
                  + {{(TSW-TW){cap_time[(h*HALF+j)*TW+TW-1]}}, cap_time[(h*HALF+j)*TW +: TW]};
            end
            if (cap_triga[h*HALF+j]) begin
               half_ncha_c[h] = half_ncha_c[h] + 4'd1;
               half_asum_c[h] = half_asum_c[h]
                  + {{(ASW-AW){1'b0}}, cap_ampl[(h*HALF+j)*AW +: AW]};
            end
         end
      end
   end

   // Half-sums settle within the window between capture (7) and update (3).
   always_ff @(posedge clk320 or negedge rst_n) begin
      if (!rst_n) begin
         half_ncht_q <= '0;
         half_ncha_q <= '0;
         half_tsum_q <= '0;
         half_asum_q <= '0;
      end else begin
         half_ncht_q <= half_ncht_c;
         half_ncha_q <= half_ncha_c;
         half_tsum_q <= half_tsum_c;
         half_asum_q <= half_asum_c;
      end
   end

   logic [CW-1:0]  ncht_sum, ncha_sum;
   logic [TSW-1:0] tsum_sum;
   logic [ASW-1:0] asum_sum;

   assign ncht_sum = half_ncht_q[0] + half_ncht_q[1];
   assign ncha_sum = half_ncha_q[0] + half_ncha_q[1];
   assign tsum_sum = half_tsum_q[0] + half_tsum_q[1];
   assign asum_sum = half_asum_q[0] + half_asum_q[1];

   always_ff @(posedge clk320 or negedge rst_n) begin
      if (!rst_n) begin
         tcm_req <= 1'b0;
         tt      <= '0;
         ta      <= '0;
      end else if (mt_cou == 3'd3) begin
         tcm_req <= (ncht_sum != '0);
         tt      <= {ncht_sum, tsum_sum};
         ta      <= {ncha_sum, asum_sum};
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_trigger_wrapper.sv
`timescale 1ns/1ps
`default_nettype none
// Self-checking bench for trigger_wrapper: integer reference model compared
// every cycle, plus directed cases with hand-computed expected outputs.
module tb_trigger_wrapper;

   logic         clk320 = 1'b0;
   logic         rst_n = 1'b0;
   logic [2:0]   mt_cou = 3'd0;
   logic [11:0]  CH_trigt = '0;
   logic [11:0]  CH_triga = '0;
   logic [11:0]  CH_trigb = '0;
   logic [119:0] CH_TIME_T = '0;
   logic [155:0] CH_ampl0 = '0;
   logic         tcm_req;
   logic [17:0]  tt;
   logic [20:0]  ta;

   int checks = 0;
   int errors = 0;

   always #2 clk320 = ~clk320;

   trigger_wrapper #(.NCH(12), .TW(10), .AW(13)) dut (
      .clk320    (clk320),
      .rst_n     (rst_n),
      .mt_cou    (mt_cou),
      .CH_trigt  (CH_trigt),
      .CH_triga  (CH_triga),
      .CH_trigb  (CH_trigb),
      .CH_TIME_T (CH_TIME_T),
      .CH_ampl0  (CH_ampl0),
      .tcm_req   (tcm_req),
      .tt        (tt),
      .ta        (ta)
   );

   // Reference model: integer counts/sums of the BC captured at phase 7,
   // published at the next phase-3 edge.
   int              cap_nt = 0, cap_ts = 0, cap_na = 0, cap_as = 0;
   logic [17:0]     exp_tt = '0;
   logic [20:0]     exp_ta = '0;
   logic            exp_req = 1'b0;
   logic signed [9:0] tval;

   always @(posedge clk320 or negedge rst_n) begin
      if (!rst_n) begin
         cap_nt = 0; cap_ts = 0; cap_na = 0; cap_as = 0;
         exp_tt = '0; exp_ta = '0; exp_req = 1'b0;
      end else if (mt_cou == 3'd3) begin
         exp_tt  = {cap_nt[3:0], cap_ts[13:0]};
         exp_ta  = {cap_na[3:0], cap_as[16:0]};
         exp_req = (cap_nt != 0);
      end else if (mt_cou == 3'd7) begin
         cap_nt = 0; cap_ts = 0; cap_na = 0; cap_as = 0;
         for (int i = 0; i < 12; i++) begin
            if (CH_trigt[i] && CH_trigb[i]) begin
               cap_nt = cap_nt + 1;
               tval   = CH_TIME_T[i*10 +: 10];
               cap_ts = cap_ts + int'(tval);
            end
            if (CH_triga[i]) begin
               cap_na = cap_na + 1;
               cap_as = cap_as + int'(CH_ampl0[i*13 +: 13]);
            end
         end
      end
   end

   always @(negedge clk320) begin
      checks = checks + 1;
      if (tt !== exp_tt || ta !== exp_ta || tcm_req !== exp_req) begin
         errors = errors + 1;
         $display("FAIL cycle_cmp t=%0t got tt=%h ta=%h req=%b exp tt=%h ta=%h req=%b",
                  $time, tt, ta, tcm_req, exp_tt, exp_ta, exp_req);
      end
   end

   task automatic next_cycle();
      @(posedge clk320);
      #1;
      mt_cou = mt_cou + 3'd1;
   endtask

   task automatic wait_phase(input logic [2:0] p);
      for (int k = 0; k < 8 && mt_cou != p; k++) next_cycle();
   endtask

   task automatic clear_inputs();
      CH_trigt = '0; CH_triga = '0; CH_trigb = '0;
      CH_TIME_T = '0; CH_ampl0 = '0;
   endtask

   task automatic set_ch(input int i, input logic t, input logic b, input logic a,
                         input logic [9:0] tm, input logic [12:0] am);
      CH_trigt[i] = t;
      CH_trigb[i] = b;
      CH_triga[i] = a;
      CH_TIME_T[i*10 +: 10] = tm;
      CH_ampl0[i*13 +: 13]  = am;
   endtask

   // Literal check of DUT and model against a hand-computed value.
   task automatic check_out(input string name, input logic [17:0] ett,
                            input logic [20:0] eta, input logic ereq);
      checks = checks + 1;
      if (tt !== ett || ta !== eta || tcm_req !== ereq ||
          exp_tt !== ett || exp_ta !== eta || exp_req !== ereq) begin
         errors = errors + 1;
         $display("FAIL %s got tt=%h ta=%h req=%b model tt=%h ta=%h req=%b exp tt=%h ta=%h req=%b",
                  name, tt, ta, tcm_req, exp_tt, exp_ta, exp_req, ett, eta, ereq);
      end
   endtask

   // Inputs must already be set; captures at phase 7, checks at update and end of hold.
   task automatic capture_and_check(input string name, input logic [17:0] ett,
                                    input logic [20:0] eta, input logic ereq);
      next_cycle();
      clear_inputs();
      wait_phase(3'd3);
      next_cycle();
      check_out(name, ett, eta, ereq);
      repeat (7) next_cycle();
      check_out({name, "_hold"}, ett, eta, ereq);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) next_cycle();
      rst_n = 1'b1;

      repeat (24) next_cycle();
      check_out("idle_zero", 18'd0, 21'd0, 1'b0);

      wait_phase(3'd7);
      set_ch(0, 1'b1, 1'b1, 1'b1, 10'd5, 13'd100);
      capture_and_check("ch0_single", {4'd1, 14'd5}, {4'd1, 17'd100}, 1'b1);

      wait_phase(3'd7);
      for (int i = 0; i < 12; i++) set_ch(i, 1'b1, 1'b1, 1'b1, 10'h200, 13'h1FFF);
      capture_and_check("all_extreme", {4'd12, 14'h2800}, {4'd12, 17'd98292}, 1'b1);

      wait_phase(3'd7);
      set_ch(3, 1'b1, 1'b0, 1'b1, 10'd200, 13'd50);
      capture_and_check("ch3_no_gate", 18'd0, {4'd1, 17'd50}, 1'b0);

      wait_phase(3'd7);
      set_ch(4, 1'b1, 1'b1, 1'b0, 10'h3FF, 13'd77);
      set_ch(9, 1'b1, 1'b1, 1'b1, 10'd20, 13'd8);
      capture_and_check("mixed_neg", {4'd2, 14'd19}, {4'd1, 17'd8}, 1'b1);

      wait_phase(3'd2);
      set_ch(2, 1'b1, 1'b1, 1'b1, 10'd33, 13'd44);
      next_cycle();
      clear_inputs();
      wait_phase(3'd7);
      capture_and_check("off_phase", 18'd0, 21'd0, 1'b0);

      wait_phase(3'd7);
      set_ch(0, 1'b1, 1'b1, 1'b1, 10'd1, 13'd10);
      set_ch(1, 1'b1, 1'b1, 1'b1, 10'd2, 13'd20);
      set_ch(2, 1'b1, 1'b1, 1'b1, 10'd3, 13'd30);
      next_cycle();
      clear_inputs();
      wait_phase(3'd1);
      rst_n = 1'b0;
      #0.5;
      check_out("reset_async", 18'd0, 21'd0, 1'b0);
      next_cycle();
      next_cycle();
      rst_n = 1'b1;
      wait_phase(3'd3);
      next_cycle();
      check_out("reset_discard", 18'd0, 21'd0, 1'b0);

      for (int c = 0; c < 640; c++) begin
         next_cycle();
         CH_trigt  = 12'($urandom);
         CH_triga  = 12'($urandom);
         CH_trigb  = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom);
         CH_TIME_T = 120'({$urandom, $urandom, $urandom, $urandom});
         CH_ampl0  = ($urandom_range(0, 7) == 0) ? '1 :
                     156'({$urandom, $urandom, $urandom, $urandom, $urandom});
         if ($urandom_range(0, 249) == 0) begin
            rst_n = 1'b0;
            next_cycle();
            rst_n = 1'b1;
         end
      end

      clear_inputs();
      repeat (10) next_cycle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
